// File: rtl/rob_pkg.sv
// rob_pkg: shared widths, FSM state and entry layout for rob_multi_cmpl.
package rob_pkg;
  localparam int PR_W = 6;
  localparam int AR_W = 5;
  localparam int ADDR_W = 32;
  typedef enum logic {IDLE, RECOVER} rob_state_t;
  typedef struct packed {
    logic valid;
    logic done;
    logic cf;
    logic MemOp;
    logic RegDest;
    logic [PR_W-1:0] PR_old;
    logic [PR_W-1:0] PR_new;
    logic [AR_W-1:0] rd;
    logic old_valid;
    logic [ADDR_W-1:0] addr;
  } rob_entry_t;
endpackage

// File: rtl/rob_multi_cmpl_if.sv
// rob_multi_cmpl_if: dispatch/completion/retire/rollback bundle; perf ports only with ROB_PERF_CNT_EN.
interface rob_multi_cmpl_if #(
  parameter int DEPTH = 16,
  parameter int N_CMPL = 2
);
  import rob_pkg::*;
  localparam int IDX_W = $clog2(DEPTH);
  logic isDispatch, MemOp, RegDest, PR_old_valid, hazard_stall;
  logic [PR_W-1:0] PR_old_DP, PR_new_DP;
  logic [AR_W-1:0] rd_DP;
  logic [IDX_W-1:0] dp_rob;
  logic [N_CMPL-1:0] complete, changeFlow;
  logic [N_CMPL*IDX_W-1:0] rob_number;
  logic [N_CMPL*ADDR_W-1:0] jb_addr;
  logic retire_reg, retire_LWST, full, empty, changeFlow_out;
  logic recover, stall_recover, RegDest_out, old_valid_out;
  logic [PR_W-1:0] PR_old_RT, PR_old_flush, PR_new_flush;
  logic [IDX_W-1:0] retire_rob, out_rob_num;
  logic [IDX_W:0] count;
  logic [ADDR_W-1:0] changeFlow_addr;
  logic [AR_W-1:0] rd_flush;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_retired;
  logic [15:0] perf_flushed;
`endif
  modport slave (
    input isDispatch, MemOp, RegDest, PR_old_DP, PR_new_DP, rd_DP, PR_old_valid, hazard_stall,
    input complete, rob_number, changeFlow, jb_addr,
    output dp_rob, retire_reg, PR_old_RT, retire_LWST, retire_rob, full, empty, count,
    output changeFlow_out, changeFlow_addr, recover, stall_recover, RegDest_out, old_valid_out,
    output PR_old_flush, PR_new_flush, rd_flush, out_rob_num
`ifdef ROB_PERF_CNT_EN
    , output perf_retired, perf_flushed
`endif
  );
  modport master (
    output isDispatch, MemOp, RegDest, PR_old_DP, PR_new_DP, rd_DP, PR_old_valid, hazard_stall,
    output complete, rob_number, changeFlow, jb_addr,
    input dp_rob, retire_reg, PR_old_RT, retire_LWST, retire_rob, full, empty, count,
    input changeFlow_out, changeFlow_addr, recover, stall_recover, RegDest_out, old_valid_out,
    input PR_old_flush, PR_new_flush, rd_flush, out_rob_num
`ifdef ROB_PERF_CNT_EN
    , input perf_retired, perf_flushed
`endif
  );
endinterface

// File: rtl/rob_entry_array.sv
// rob_entry_array: ROB entry storage with one write, N_CMPL done/cf set ports, one clear port, head/tail reads.
module rob_entry_array
  import rob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int N_CMPL = 2,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  input logic wr_en,
  input logic [IDX_W-1:0] wr_idx,
  input rob_entry_t wr_entry,
  input logic [N_CMPL-1:0] cmpl_en,
  input logic [N_CMPL-1:0] cmpl_cf,
  input logic [N_CMPL-1:0][IDX_W-1:0] cmpl_idx,
  input logic [N_CMPL-1:0][ADDR_W-1:0] cmpl_addr,
  input logic clr_en,
  input logic [IDX_W-1:0] clr_idx,
  input logic [IDX_W-1:0] head_idx,
  input logic [IDX_W-1:0] tail_idx,
  output rob_entry_t head_entry,
  output rob_entry_t tail_entry
);
  rob_entry_t [DEPTH-1:0] entries_q, entries_d;
  // Ports are applied highest first so the lowest port's redirect address lands last.
  always_comb begin
    entries_d = entries_q;
    for (int i = N_CMPL - 1; i >= 0; i--) begin
      if (cmpl_en[i] && entries_q[cmpl_idx[i]].valid) begin
        entries_d[cmpl_idx[i]].done = 1'b1;
        if (cmpl_cf[i]) begin
          entries_d[cmpl_idx[i]].cf = 1'b1;
          entries_d[cmpl_idx[i]].addr = cmpl_addr[i];
        end
      end
    end
    if (wr_en) entries_d[wr_idx] = wr_entry;
    if (clr_en) entries_d[clr_idx] = '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) entries_q <= '0;
    else entries_q <= entries_d;
  end
  assign head_entry = entries_q[head_idx];
  assign tail_entry = entries_q[tail_idx];
endmodule

// File: rtl/rob_multi_cmpl.sv
// rob_multi_cmpl: reorder buffer with N_CMPL completion ports, in-order retire and youngest-first rollback.
// Optional perf counters (perf_retired/perf_flushed) under ROB_PERF_CNT_EN.
module rob_multi_cmpl
  import rob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int N_CMPL = 2
) (
  input logic clk,
  input logic rst,
  rob_multi_cmpl_if.slave rif
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PW = IDX_W + 1;
  rob_state_t state_q, state_d;
  logic [IDX_W:0] head_q, head_d, tail_q, tail_d, cnt;
  logic [IDX_W-1:0] last_idx;
  logic idle, rec, rt_fire, dp_fire;
  rob_entry_t head_e, tail_e, wr_e;
  logic [N_CMPL-1:0] cmpl_en;
  logic [N_CMPL-1:0][IDX_W-1:0] cmpl_idx;
  logic [N_CMPL-1:0][ADDR_W-1:0] cmpl_addr;
  logic unused_ok;
  always_comb begin
    cnt = tail_q - head_q;
    last_idx = tail_q[IDX_W-1:0] - IDX_W'(1);
    idle = state_q == IDLE;
    rec = state_q == RECOVER;
    rt_fire = idle & head_e.valid & head_e.done;
    dp_fire = rif.isDispatch & (cnt != PW'(DEPTH)) & ~rif.hazard_stall & idle;
    wr_e = '{valid: 1'b1, done: 1'b0, cf: 1'b0, MemOp: rif.MemOp, RegDest: rif.RegDest,
             PR_old: rif.PR_old_DP, PR_new: rif.PR_new_DP, rd: rif.rd_DP,
             old_valid: rif.PR_old_valid, addr: '0};
    for (int i = 0; i < N_CMPL; i++) begin
      cmpl_en[i] = rif.complete[i] & idle;
      cmpl_idx[i] = rif.rob_number[i*IDX_W +: IDX_W];
      cmpl_addr[i] = rif.jb_addr[i*ADDR_W +: ADDR_W];
    end
  end
  rob_entry_array #(.DEPTH(DEPTH), .N_CMPL(N_CMPL)) u_entries (
    .clk(clk),
    .rst(rst),
    .wr_en(dp_fire),
    .wr_idx(tail_q[IDX_W-1:0]),
    .wr_entry(wr_e),
    .cmpl_en(cmpl_en),
    .cmpl_cf(rif.changeFlow),
    .cmpl_idx(cmpl_idx),
    .cmpl_addr(cmpl_addr),
    .clr_en(rt_fire | rec),
    .clr_idx(rec ? last_idx : head_q[IDX_W-1:0]),
    .head_idx(head_q[IDX_W-1:0]),
    .tail_idx(last_idx),
    .head_entry(head_e),
    .tail_entry(tail_e)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
  // A mispredict with nothing younger behind it needs no rollback.
  always_comb begin
    head_d = head_q + PW'(rt_fire);
    tail_d = rec ? tail_q - PW'(1) : tail_q + PW'(dp_fire);
    state_d = rec ? (last_idx == head_q[IDX_W-1:0] ? IDLE : RECOVER)
                  : (rt_fire & head_e.cf & (tail_q != head_q + PW'(1)) ? RECOVER : IDLE);
  end
  always_comb begin
    rif.dp_rob = tail_q[IDX_W-1:0];
    rif.retire_reg = rt_fire & head_e.RegDest & head_e.old_valid;
    rif.PR_old_RT = rt_fire ? head_e.PR_old : '0;
    rif.retire_LWST = rt_fire & head_e.MemOp;
    rif.retire_rob = rt_fire ? head_q[IDX_W-1:0] : '0;
    rif.full = cnt == PW'(DEPTH);
    rif.empty = cnt == '0;
    rif.count = cnt;
    rif.changeFlow_out = rt_fire & head_e.cf;
    rif.changeFlow_addr = rt_fire & head_e.cf ? head_e.addr : '0;
    rif.recover = rec;
    rif.stall_recover = rec;
    rif.RegDest_out = rec & tail_e.RegDest;
    rif.old_valid_out = rec & tail_e.old_valid;
    rif.PR_old_flush = rec ? tail_e.PR_old : '0;
    rif.PR_new_flush = rec ? tail_e.PR_new : '0;
    rif.rd_flush = rec ? tail_e.rd : '0;
    rif.out_rob_num = rec ? last_idx : '0;
  end
  assign unused_ok = ^{head_e.PR_new, head_e.rd, tail_e.valid, tail_e.done, tail_e.cf,
                       tail_e.MemOp, tail_e.addr};
`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [15:0] perf_flushed_q, perf_flushed_d;
  always_comb begin
    perf_retired_d = perf_retired_q + 32'(rt_fire && perf_retired_q != '1);
    perf_flushed_d = perf_flushed_q + 16'(rec && perf_flushed_q != '1);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_retired_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end
  assign rif.perf_retired = perf_retired_q;
  assign rif.perf_flushed = perf_flushed_q;
`endif
endmodule
